// File: rtl/fetch_stage.sv
// Fetch stage + IF/ID register: owns PC and next-PC select; InstrD/PCD follow PCF by one cycle.
// No handshake: StallF/StallD hold state, FlushD inserts a bubble, and redirects override StallF.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             PCSrcWB,
  input  logic             BranchTakenE,
  input  logic [31:0]      ResultW,
  input  logic [31:0]      ALUResultE,
  input  logic [31:0]      InstrF,
  input  logic             CntClr,
  output logic [31:0]      PCF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCD,
  output logic [31:0]      PCPlus8D,
  output logic             ValidD,
  output logic             AlignErr,
  output logic [CNT_W-1:0] FetchCnt,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic        redirect;
  logic [31:0] rawTarget;
  logic        loadD;
  logic        stallEvt;

  // Writeback redirect belongs to the older instruction, so it beats Execute.
  assign redirect  = PCSrcWB | BranchTakenE;
  assign rawTarget = PCSrcWB ? ResultW : ALUResultE;
  assign loadD     = !FlushD && !StallD;
  assign stallEvt  = StallF && !redirect;
  assign PCPlus8D  = PCD + 32'd8;

  always_ff @(posedge clk) begin
    if (reset) begin
      PCF      <= RESET_PC;
      InstrD   <= '0;
      PCD      <= '0;
      ValidD   <= 1'b0;
      AlignErr <= 1'b0;
      FetchCnt <= '0;
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (redirect) begin
        PCF <= {rawTarget[31:2], 2'b00};
        if (|rawTarget[1:0]) AlignErr <= 1'b1;
      end else if (!StallF) begin
        PCF <= PCF + 32'd4;
      end

      if (FlushD) begin
        InstrD <= '0;
        PCD    <= '0;
        ValidD <= 1'b0;
      end else if (!StallD) begin
        InstrD <= InstrF;
        PCD    <= PCF;
        ValidD <= 1'b1;
      end

      if (CntClr) begin
        FetchCnt <= '0;
        StallCnt <= '0;
        FlushCnt <= '0;
      end else begin
        if (loadD && FetchCnt != CNT_MAX)    FetchCnt <= FetchCnt + CNT_ONE;
        if (stallEvt && StallCnt != CNT_MAX) StallCnt <= StallCnt + CNT_ONE;
        if (FlushD && FlushCnt != CNT_MAX)   FlushCnt <= FlushCnt + CNT_ONE;
      end
    end
  end

  // The hazard unit is expected never to raise both redirects together.
  assert property (@(posedge clk) disable iff (reset) !(PCSrcWB && BranchTakenE))
    else $warning("fetch_stage: PCSrcWB and BranchTakenE asserted together");

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: table of per-cycle vectors checked through an expectation queue,
// followed by hand-written sequences for sticky alignment, counter saturation and reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallF, StallD, FlushD, PCSrcWB, BranchTakenE, CntClr;
  logic [31:0] ResultW, ALUResultE, InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus8D;
  logic        ValidD, AlignErr;
  logic [15:0] FetchCnt, StallCnt, FlushCnt;

  int checks = 0;
  int failures = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcWB(PCSrcWB), .BranchTakenE(BranchTakenE), .ResultW(ResultW),
    .ALUResultE(ALUResultE), .InstrF(InstrF), .CntClr(CntClr), .PCF(PCF),
    .InstrD(InstrD), .PCD(PCD), .PCPlus8D(PCPlus8D), .ValidD(ValidD),
    .AlignErr(AlignErr), .FetchCnt(FetchCnt), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  // Instruction memory model: echoes the fetch address with a recognisable top nibble.
  assign InstrF = PCF | 32'hE000_0000;

  typedef struct {
    logic [31:0] pcf;
    logic [31:0] pcd;
    logic        valid;
    logic        align;
    logic [15:0] fetch;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  typedef struct {
    logic        sF, sD, fD, pcW, brE, clr;
    logic [31:0] resW, alu;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic checkState(input exp_t e, input string tag);
    logic [31:0] expInstr;
    expInstr = e.valid ? (e.pcd | 32'hE000_0000) : 32'h0;
    chk({tag, ".PCF"}, PCF, e.pcf);
    chk({tag, ".PCD"}, PCD, e.pcd);
    chk({tag, ".InstrD"}, InstrD, expInstr);
    chk({tag, ".PCPlus8D"}, PCPlus8D, e.pcd + 32'd8);
    chk({tag, ".ValidD"}, {31'b0, ValidD}, {31'b0, e.valid});
    chk({tag, ".AlignErr"}, {31'b0, AlignErr}, {31'b0, e.align});
    chk({tag, ".FetchCnt"}, {16'b0, FetchCnt}, {16'b0, e.fetch});
    chk({tag, ".StallCnt"}, {16'b0, StallCnt}, {16'b0, e.stall});
    chk({tag, ".FlushCnt"}, {16'b0, FlushCnt}, {16'b0, e.flush});
  endtask

  task automatic addv(input logic sF, input logic sD, input logic fD, input logic pcW,
                      input logic brE, input logic clr, input logic [31:0] resW,
                      input logic [31:0] alu, input logic [31:0] pcf, input logic [31:0] pcd,
                      input logic valid, input logic align, input logic [15:0] fetch,
                      input logic [15:0] stall, input logic [15:0] flush);
    vec_t v;
    v.sF = sF; v.sD = sD; v.fD = fD; v.pcW = pcW; v.brE = brE; v.clr = clr;
    v.resW = resW; v.alu = alu;
    v.e = '{pcf: pcf, pcd: pcd, valid: valid, align: align, fetch: fetch, stall: stall, flush: flush};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic sF, input logic sD, input logic fD, input logic pcW,
                       input logic brE, input logic clr, input logic [31:0] resW,
                       input logic [31:0] alu);
    StallF = sF; StallD = sD; FlushD = fD; PCSrcWB = pcW; BranchTakenE = brE;
    CntClr = clr; ResultW = resW; ALUResultE = alu;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  exp_t rstExp;

  initial begin
    rstExp = '{pcf: 32'h0, pcd: 32'h0, valid: 1'b0, align: 1'b0, fetch: 16'h0, stall: 16'h0, flush: 16'h0};

    // Reset asserted together with stall/flush: those inputs must be ignored.
    drive(1, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    tick();
    checkState(rstExp, "reset");
    reset = 1'b0;

    //   sF sD fD pW bE cl resW           alu            PCF            PCD            V  A  fet  stl  fl
    addv(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0004, 32'h0000_0000, 1, 0, 1,   0,   0);
    addv(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0008, 32'h0000_0004, 1, 0, 2,   0,   0);
    addv(1, 1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0008, 32'h0000_0004, 1, 0, 2,   1,   0);
    addv(1, 1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0008, 32'h0000_0004, 1, 0, 2,   2,   0);
    addv(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_000C, 32'h0000_0008, 1, 0, 3,   2,   0);
    addv(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0010, 32'h0000_000C, 1, 0, 4,   2,   0);
    addv(1, 0, 1, 0, 1, 0, 32'h0,         32'h0000_0100, 32'h0000_0100, 32'h0000_0000, 0, 0, 4,   2,   1);
    addv(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0104, 32'h0000_0100, 1, 0, 5,   2,   1);
    addv(0, 1, 1, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0108, 32'h0000_0000, 0, 0, 5,   2,   2);
    addv(0, 1, 0, 1, 0, 0, 32'h0000_0203, 32'h0,         32'h0000_0200, 32'h0000_0000, 0, 1, 5,   2,   2);
    addv(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0204, 32'h0000_0200, 1, 1, 6,   2,   2);
    addv(0, 0, 0, 1, 1, 0, 32'h0000_0300, 32'h0000_0400, 32'h0000_0300, 32'h0000_0204, 1, 1, 7,   2,   2);
    addv(0, 0, 0, 0, 1, 0, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0300, 1, 1, 8,   2,   2);
    addv(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0000, 32'hFFFF_FFFC, 1, 1, 9,   2,   2);
    addv(1, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0000, 32'h0000_0000, 1, 1, 10,  3,   2);
    addv(1, 0, 1, 0, 0, 1, 32'h0,         32'h0,         32'h0000_0000, 32'h0000_0000, 0, 1, 0,   0,   0);

    foreach (vecs[i]) begin
      drive(vecs[i].sF, vecs[i].sD, vecs[i].fD, vecs[i].pcW, vecs[i].brE, vecs[i].clr,
            vecs[i].resW, vecs[i].alu);
      sbq.push_back(vecs[i].e);
      tick();
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard: queue empty at vector %0d", i);
      end else begin
        checkState(sbq.pop_front(), $sformatf("v%0d", i));
      end
    end

    // AlignErr must survive ordinary traffic.
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    repeat (10) tick();
    chk("sticky.AlignErr", {31'b0, AlignErr}, 32'h1);
    chk("sticky.PCF", PCF, 32'h0000_0028);
    chk("sticky.FetchCnt", {16'b0, FetchCnt}, 32'd10);

    // FlushCnt saturation.
    drive(0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
    repeat (65534) tick();
    chk("sat.FlushCnt.prev", {16'b0, FlushCnt}, 32'h0000_FFFE);
    repeat (5) tick();
    chk("sat.FlushCnt", {16'b0, FlushCnt}, 32'h0000_FFFF);
    chk("sat.FetchCnt", {16'b0, FetchCnt}, 32'd10);
    chk("sat.StallCnt", {16'b0, StallCnt}, 32'd0);
    chk("sat.ValidD", {31'b0, ValidD}, 32'h0);

    // Clear beats increment in the same cycle.
    drive(0, 0, 1, 0, 0, 1, 32'h0, 32'h0);
    tick();
    chk("clr.FlushCnt", {16'b0, FlushCnt}, 32'd0);
    chk("clr.FetchCnt", {16'b0, FetchCnt}, 32'd0);
    drive(0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
    tick();
    chk("clr.FlushCnt.resume", {16'b0, FlushCnt}, 32'd1);

    // Reset wins over a misaligned redirect, stall and flush.
    drive(1, 1, 1, 1, 0, 0, 32'h0000_0203, 32'h0);
    reset = 1'b1;
    tick();
    checkState(rstExp, "midreset");
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
